// File: rtl/rr_arb_requester.sv
// Four-channel burst requester for a 4-way round-robin arbiter.
// Each channel queues burst commands and holds its request until the burst is granted; grant-protocol errors are flagged.
module rr_arb_requester #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         cmd_valid,
  input  logic [4*LEN_W-1:0] cmd_len,
  output logic [3:0]         cmd_ready,
  output logic               req1,
  output logic               req2,
  output logic               req3,
  output logic               req4,
  input  logic               gnt1,
  input  logic               gnt2,
  input  logic               gnt3,
  input  logic               gnt4,
  output logic [3:0]         done,
  output logic               err_multi_gnt,
  output logic [3:0]         err_spurious_gnt,
  output logic [3:0]         err_timeout
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned CW     = AW + 1;
  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_XFER, ST_GAP} state_e;

  logic [3:0] gnt;
  logic [3:0] req;
  logic       multi_q;

  assign gnt  = {gnt4, gnt3, gnt2, gnt1};
  assign req1 = req[0];
  assign req2 = req[1];
  assign req3 = req[2];
  assign req4 = req[3];
  assign err_multi_gnt = multi_q;

  // More than one grant bit set in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      multi_q <= 1'b0;
    end else if ((gnt & (gnt - 4'd1)) != 4'd0) begin
      multi_q <= 1'b1;
    end
  end

  for (genvar n = 0; n < 4; n++) begin : g_ch
    logic [LEN_W-1:0]  mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic              ready_q;
    logic              push, pop;
    logic [LEN_W-1:0]  head_len;
    state_e            state_q;
    logic [LEN_W-1:0]  beat_cnt_q;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic              req_q, req_prev_q, done_q, spur_q, tmo_q;

    assign push     = cmd_valid[n] && ready_q;
    assign pop      = (state_q == ST_GAP);
    assign head_len = mem_q[rd_ptr_q];

    assign cmd_ready[n]        = ready_q;
    assign req[n]              = req_q;
    assign done[n]             = done_q;
    assign err_spurious_gnt[n] = spur_q;
    assign err_timeout[n]      = tmo_q;

    always_comb begin
      count_d = count_q;
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (!push && pop) begin
        count_d = count_q - CW'(1);
      end
    end

    // Command FIFO; the head entry is popped in the cycle after the final beat.
    always_ff @(posedge clk) begin
      if (reset) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        ready_q  <= 1'b1;
      end else begin
        if (push) begin
          mem_q[wr_ptr_q] <= cmd_len[n*LEN_W +: LEN_W];
          wr_ptr_q        <= wr_ptr_q + AW'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + AW'(1);
        end
        count_q <= count_d;
        ready_q <= (count_d != CW'(DEPTH));
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q    <= ST_IDLE;
        beat_cnt_q <= '0;
        wait_cnt_q <= '0;
        req_q      <= 1'b0;
        req_prev_q <= 1'b0;
        done_q     <= 1'b0;
        spur_q     <= 1'b0;
        tmo_q      <= 1'b0;
      end else begin
        done_q     <= 1'b0;
        req_prev_q <= req_q;
        // A single-cycle grant tail after the request drops is tolerated.
        if (gnt[n] && !req_q && !req_prev_q) begin
          spur_q <= 1'b1;
        end
        case (state_q)
          ST_IDLE: begin
            if (count_q != '0) begin
              state_q    <= ST_REQ;
              req_q      <= 1'b1;
              beat_cnt_q <= '0;
              wait_cnt_q <= '0;
            end
          end
          ST_REQ: begin
            if (gnt[n]) begin
              if (head_len == '0) begin
                state_q <= ST_GAP;
                req_q   <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q    <= ST_XFER;
                beat_cnt_q <= LEN_W'(1);
              end
            end else begin
              if (wait_cnt_q != WAIT_W'(TIMEOUT)) begin
                wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
              end
              if (wait_cnt_q >= WAIT_W'(TIMEOUT - 1)) begin
                tmo_q <= 1'b1;
              end
            end
          end
          ST_XFER: begin
            if (gnt[n]) begin
              if (beat_cnt_q == head_len) begin
                state_q <= ST_GAP;
                req_q   <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                beat_cnt_q <= beat_cnt_q + LEN_W'(1);
              end
            end
          end
          ST_GAP: begin
            state_q <= ST_IDLE;
          end
          default: begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rr_arb_requester.sv
// Directed bench for rr_arb_requester: a queue-based channel model is checked every cycle,
// plus hand-computed latency, count and error-flag expectations.
module tb_rr_arb_requester;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned LEN_W   = 4;
  localparam int unsigned TIMEOUT = 16;

  logic               clk = 1'b0;
  logic               reset;
  logic [3:0]         cmd_valid;
  logic [4*LEN_W-1:0] cmd_len;
  logic [3:0]         cmd_ready;
  logic               req1, req2, req3, req4;
  logic [3:0]         gnt_v;
  logic [3:0]         done;
  logic               err_multi_gnt;
  logic [3:0]         err_spurious_gnt;
  logic [3:0]         err_timeout;
  logic [3:0]         req_v;

  assign req_v = {req4, req3, req2, req1};

  always #5 clk = ~clk;

  rr_arb_requester #(.DEPTH(DEPTH), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_len(cmd_len), .cmd_ready(cmd_ready),
    .req1(req1), .req2(req2), .req3(req3), .req4(req4),
    .gnt1(gnt_v[0]), .gnt2(gnt_v[1]), .gnt3(gnt_v[2]), .gnt4(gnt_v[3]),
    .done(done), .err_multi_gnt(err_multi_gnt),
    .err_spurious_gnt(err_spurious_gnt), .err_timeout(err_timeout)
  );

  int vecs   = 0;
  int miscmp = 0;

  // Model: per-channel command queue, beats received and grant wait, all in plain integers.
  int         q [4][$];
  int         beats [4];
  int         waited [4];
  logic [3:0] m_req, m_prev, m_done, m_rdy, m_spur, m_tmo;
  logic       m_multi;
  logic       m_valid = 1'b0;

  int  hcnt, dcnt, ptr, c;
  int  dper [4];
  bit  acc;
  bit  pat3 [12] = '{1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0};

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    vecs++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [3:0] nreq, ndone;
    int sz;
    if (reset) begin
      for (int n = 0; n < 4; n++) begin
        q[n].delete();
        beats[n]  = 0;
        waited[n] = 0;
      end
      m_req = '0; m_prev = '0; m_done = '0; m_rdy = 4'hF;
      m_spur = '0; m_tmo = '0; m_multi = 1'b0; m_valid = 1'b1;
      return;
    end
    if (!m_valid) return;
    if ($countones(gnt_v) > 1) m_multi = 1'b1;
    nreq  = m_req;
    ndone = '0;
    for (int n = 0; n < 4; n++) begin
      if (gnt_v[n] && !m_req[n] && !m_prev[n]) m_spur[n] = 1'b1;
      if (m_done[n]) void'(q[n].pop_front());
      sz = q[n].size();
      if (m_req[n]) begin
        if (gnt_v[n]) begin
          beats[n]++;
          if (beats[n] == q[n][0] + 1) begin
            nreq[n]  = 1'b0;
            ndone[n] = 1'b1;
          end
        end else if (beats[n] == 0) begin
          waited[n]++;
          if (waited[n] >= int'(TIMEOUT)) m_tmo[n] = 1'b1;
        end
      end else if (!m_done[n] && sz > 0) begin
        nreq[n]   = 1'b1;
        beats[n]  = 0;
        waited[n] = 0;
      end
      if (cmd_valid[n] && m_rdy[n]) q[n].push_back(int'(cmd_len[n*LEN_W +: LEN_W]));
      m_rdy[n] = (q[n].size() != int'(DEPTH));
    end
    m_prev = m_req;
    m_req  = nreq;
    m_done = ndone;
  endtask

  task automatic compare();
    if (!m_valid) return;
    check("req", req_v, m_req);
    check("done", done, m_done);
    check("cmd_ready", cmd_ready, m_rdy);
    check("err_spurious_gnt", err_spurious_gnt, m_spur);
    check("err_timeout", err_timeout, m_tmo);
    check("err_multi_gnt", {3'b0, err_multi_gnt}, {3'b0, m_multi});
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic wait_req(input int n);
    int k = 0;
    while (!req_v[n] && k < 10) begin
      step();
      k++;
    end
    vecs++;
    if (!req_v[n]) begin
      miscmp++;
      $display("FAIL wait_req%0d: request never rose, got 0 expected 1", n + 1);
    end
  endtask

  initial begin
    reset = 1'b1; cmd_valid = '0; cmd_len = '0; gnt_v = '0;
    step(); step();
    check("rst_ready", cmd_ready, 4'hF);
    check("rst_req", req_v, 4'h0);
    reset = 1'b0;
    step();

    // Single burst, len=3, grant held from the third request cycle.
    cmd_len[3:0] = 4'd3; cmd_valid = 4'b0001;
    step();
    cmd_valid = '0;
    check("lat_t1", {3'b0, req_v[0]}, 4'h0);
    step();
    check("lat_t2", {3'b0, req_v[0]}, 4'h1);
    hcnt = 0; dcnt = 0;
    for (int k = 0; k < 12; k++) begin
      if (req_v[0]) hcnt++;
      if (done[0]) dcnt++;
      gnt_v[0] = (k >= 2) && req_v[0];
      step();
    end
    gnt_v = '0;
    check("burst_req_cycles", 4'(hcnt), 4'd6);
    check("burst_done_pulses", 4'(dcnt), 4'd1);
    check("burst_err", {err_multi_gnt, 3'b0} | err_spurious_gnt | err_timeout, 4'h0);

    // Round robin across all four channels, len=1 each.
    cmd_len = {4'd1, 4'd1, 4'd1, 4'd1}; cmd_valid = 4'hF;
    step();
    cmd_valid = '0;
    ptr = 3;
    for (int n = 0; n < 4; n++) dper[n] = 0;
    for (int k = 0; k < 30; k++) begin
      for (int n = 0; n < 4; n++) if (done[n]) dper[n]++;
      gnt_v = '0;
      for (int i = 1; i <= 4; i++) begin
        c = (ptr + i) % 4;
        if (req_v[c]) begin
          gnt_v[c] = 1'b1;
          ptr = c;
          break;
        end
      end
      step();
    end
    gnt_v = '0;
    for (int n = 0; n < 4; n++) check("rr_done_pulses", 4'(dper[n]), 4'd1);
    check("rr_err", {err_multi_gnt, 3'b0} | err_spurious_gnt | err_timeout, 4'h0);

    // Preemption on ch2: two beats, three idle grant cycles, three more beats.
    cmd_len[7:4] = 4'd4; cmd_valid = 4'b0010;
    step();
    cmd_valid = '0;
    wait_req(1);
    hcnt = 0; dcnt = 0;
    for (int k = 0; k < 12; k++) begin
      if (req_v[1]) hcnt++;
      if (done[1]) dcnt++;
      gnt_v[1] = pat3[k];
      step();
    end
    gnt_v = '0;
    check("preempt_req_cycles", 4'(hcnt), 4'd8);
    check("preempt_done_pulses", 4'(dcnt), 4'd1);

    // FIFO full on ch3: four pushes fill it, fifth waits for the first pop.
    cmd_len[11:8] = 4'd0; cmd_valid = 4'b0100;
    repeat (4) step();
    check("full_ready", {3'b0, cmd_ready[2]}, 4'h0);
    check("full_req", {3'b0, req_v[2]}, 4'h1);
    repeat (3) step();
    check("full_ready_hold", {3'b0, cmd_ready[2]}, 4'h0);
    dcnt = 0;
    for (int k = 0; k < 40; k++) begin
      acc = cmd_valid[2] && cmd_ready[2];
      gnt_v[2] = req_v[2];
      if (done[2]) dcnt++;
      step();
      if (acc) cmd_valid[2] = 1'b0;
    end
    gnt_v = '0;
    check("full_done_pulses", 4'(dcnt), 4'd5);

    // Grant timeout on ch4 after 16 ungranted request cycles.
    cmd_len[15:12] = 4'd2; cmd_valid = 4'b1000;
    step();
    cmd_valid = '0;
    wait_req(3);
    for (int k = 0; k < 16; k++) begin
      if (k == 15) check("tmo_cycle16", {3'b0, err_timeout[3]}, 4'h0);
      step();
    end
    check("tmo_cycle17", {3'b0, err_timeout[3]}, 4'h1);
    repeat (3) step();
    check("tmo_sticky", {3'b0, err_timeout[3]}, 4'h1);
    dcnt = 0;
    for (int k = 0; k < 10; k++) begin
      gnt_v[3] = req_v[3];
      if (done[3]) dcnt++;
      step();
    end
    gnt_v = '0;
    check("tmo_done_pulses", 4'(dcnt), 4'd1);

    // Protocol errors, then reset mid-burst clears everything.
    gnt_v = 4'b0011;
    step();
    gnt_v = '0;
    check("multi_gnt", {3'b0, err_multi_gnt}, 4'h1);
    gnt_v = 4'b0100;
    step();
    gnt_v = '0;
    check("spurious", err_spurious_gnt, 4'b0111);
    cmd_len[3:0] = 4'd5; cmd_len[7:4] = 4'd5; cmd_valid = 4'b0011;
    step();
    cmd_valid = '0;
    wait_req(0);
    gnt_v[0] = 1'b1;
    step(); step();
    gnt_v = '0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_req", req_v, 4'h0);
    check("midrst_err", {err_multi_gnt, 3'b0} | err_spurious_gnt | err_timeout, 4'h0);
    check("midrst_ready", cmd_ready, 4'hF);
    repeat (4) step();
    check("midrst_discard", req_v, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end

endmodule
